// File: rtl/pipe_hazard_if.sv
// Pipeline-to-hazard-controller bundle: stage register fields in, forwarding
// selects, stage enables/flushes and debug counters out.
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       ex_Rw;
    logic             ex_RegWr;
    logic [1:0]       ex_MemtoReg;
    logic [4:0]       mem_Rw;
    logic             mem_RegWr;
    logic [4:0]       wr_Rw;
    logic             wr_RegWr;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             id_jump;
    logic             dmem_req;
    logic             dmem_ready;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wr_en;
    logic             mem_wr_flush;
    logic             dmem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_Rw, ex_RegWr, ex_MemtoReg,
               mem_Rw, mem_RegWr, wr_Rw, wr_RegWr, ex_rs, ex_rt,
               ex_branch_taken, id_jump, dmem_req, dmem_ready,
        input  fwd_a, fwd_b, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wr_en, mem_wr_flush, dmem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_Rw, ex_RegWr, ex_MemtoReg,
               mem_Rw, mem_RegWr, wr_Rw, wr_RegWr, ex_rs, ex_rt,
               ex_branch_taken, id_jump, dmem_req, dmem_ready,
        output fwd_a, fwd_b, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wr_en, mem_wr_flush, dmem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: ALU forwarding, load-use/branch/
// jump/memory-wait stall and flush control, plus saturating debug counters.
//
// state  | meaning
// S_RUN  | normal flow; a memory wait here starts a wait episode
// S_WAIT | holding the pipe upstream of MEM while data memory is not ready
// S_REL  | one-cycle forced release after a wait timed out
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 64,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_hazard_if.slave bus
);
    localparam int WCW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_REL} state_t;

    state_t           state, state_nxt;
    logic [WCW-1:0]   wait_cnt, wait_nxt, wait_inc;
    logic             timeout_set;
    logic             memwait, loaduse;
    logic             stall_ev, flush_ev;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             dmem_timeout;

    logic [1:0] fwd_a, fwd_b;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic       ex_mem_en, mem_wr_en, mem_wr_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_RUN;
            wait_cnt     <= '0;
            dmem_timeout <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_set)
                dmem_timeout <= 1'b1;
            if (stall_ev && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_ev && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        memwait = (state != S_REL) && bus.dmem_req && !bus.dmem_ready;
        loaduse = (bus.ex_MemtoReg == 2'b01) && bus.ex_RegWr && (bus.ex_Rw != 5'd0) &&
                  ((bus.id_use_rs && bus.id_rs == bus.ex_Rw) ||
                   (bus.id_use_rt && bus.id_rt == bus.ex_Rw));
        // Wait count the episode will have after this cycle's stall.
        wait_inc    = (state == S_WAIT) ? wait_cnt + WCW'(1) : WCW'(1);
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;

        case (state)
            S_REL: begin
                state_nxt = S_RUN;
                wait_nxt  = '0;
            end
            default: begin
                if (memwait) begin
                    if (wait_inc >= WCW'(WAIT_MAX)) begin
                        state_nxt   = S_REL;
                        wait_nxt    = '0;
                        timeout_set = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        wait_nxt  = wait_inc;
                    end
                end else begin
                    state_nxt = S_RUN;
                    wait_nxt  = '0;
                end
            end
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wr_en    = 1'b1;
        mem_wr_flush = 1'b0;

        if (state != S_REL) begin
            if (memwait) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wr_flush = 1'b1;
            end else if (bus.ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (loaduse) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (bus.id_jump) begin
                if_id_flush = 1'b1;
            end
        end

        stall_ev = !pc_en;
        flush_ev = if_id_flush;

        if (bus.mem_RegWr && bus.mem_Rw != 5'd0 && bus.mem_Rw == bus.ex_rs)
            fwd_a = 2'b01;
        else if (bus.wr_RegWr && bus.wr_Rw != 5'd0 && bus.wr_Rw == bus.ex_rs)
            fwd_a = 2'b10;
        else
            fwd_a = 2'b00;

        if (bus.mem_RegWr && bus.mem_Rw != 5'd0 && bus.mem_Rw == bus.ex_rt)
            fwd_b = 2'b01;
        else if (bus.wr_RegWr && bus.wr_Rw != 5'd0 && bus.wr_Rw == bus.ex_rt)
            fwd_b = 2'b10;
        else
            fwd_b = 2'b00;

        // Pipeline flows freely while reset is held.
        if (!rst) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_en     = 1'b1;
            id_ex_flush  = 1'b0;
            ex_mem_en    = 1'b1;
            mem_wr_en    = 1'b1;
            mem_wr_flush = 1'b0;
            fwd_a        = 2'b00;
            fwd_b        = 2'b00;
        end
    end

    assign bus.fwd_a        = fwd_a;
    assign bus.fwd_b        = fwd_b;
    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_en     = id_ex_en;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_en    = ex_mem_en;
    assign bus.mem_wr_en    = mem_wr_en;
    assign bus.mem_wr_flush = mem_wr_flush;
    assign bus.dmem_timeout = dmem_timeout;
    assign bus.stall_cnt    = stall_cnt;
    assign bus.flush_cnt    = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_if #(.CNT_W(CNT_W)) phi ();

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(phi)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: length of the current run of memory-wait stall cycles, whether
    // the next cycle is the forced release, and the debug counters.
    int m_run   = 0;
    bit m_rel   = 0;
    bit m_to    = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] fwd_of(input logic [4:0] src);
        if (phi.mem_RegWr && phi.mem_Rw != 0 && phi.mem_Rw == src) return 2'b01;
        if (phi.wr_RegWr && phi.wr_Rw != 0 && phi.wr_Rw == src) return 2'b10;
        return 2'b00;
    endfunction

    // One cycle: compare DUT with the model, advance the model, cross the edge.
    task automatic tick();
        bit mw, lu, br, jp, stall, flush, held;
        bit e_pc, e_ifen, e_iff, e_idexen, e_idexf, e_exmem, e_memwr, e_memwrf;
        logic [1:0] e_fa, e_fb;
        #1;
        held = (rst == 1'b0);
        mw = phi.dmem_req && !phi.dmem_ready && !m_rel;
        lu = phi.ex_MemtoReg == 2'b01 && phi.ex_RegWr && phi.ex_Rw != 0 &&
             ((phi.id_use_rs && phi.id_rs == phi.ex_Rw) ||
              (phi.id_use_rt && phi.id_rt == phi.ex_Rw));
        br = phi.ex_branch_taken;
        jp = phi.id_jump;
        stall = !held && !m_rel && (mw || (!br && lu));
        flush = !held && !m_rel && !mw && (br || (!lu && jp));

        e_pc     = !stall;
        e_ifen   = !stall;
        e_iff    = flush;
        e_idexen = held || m_rel || !mw;
        e_idexf  = !held && !m_rel && !mw && (br || lu);
        e_exmem  = held || m_rel || !mw;
        e_memwr  = 1'b1;
        e_memwrf = !held && !m_rel && mw;
        e_fa = held ? 2'b00 : fwd_of(phi.ex_rs);
        e_fb = held ? 2'b00 : fwd_of(phi.ex_rt);

        check("fwd_a", phi.fwd_a, e_fa);
        check("fwd_b", phi.fwd_b, e_fb);
        check("ctrl", {phi.pc_en, phi.if_id_en, phi.if_id_flush, phi.id_ex_en,
                       phi.id_ex_flush, phi.ex_mem_en, phi.mem_wr_en, phi.mem_wr_flush},
                      {e_pc, e_ifen, e_iff, e_idexen, e_idexf, e_exmem, e_memwr, e_memwrf});
        check("dmem_timeout", phi.dmem_timeout, m_to);
        check("stall_cnt", phi.stall_cnt, m_stall);
        check("flush_cnt", phi.flush_cnt, m_flush);

        if (held) begin
            m_run = 0; m_rel = 0; m_to = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (stall && m_stall < CNT_MAX) m_stall++;
            if (flush && m_flush < CNT_MAX) m_flush++;
            if (m_rel) begin
                m_rel = 0;
                m_run = 0;
            end else if (mw) begin
                m_run++;
                if (m_run >= WAIT_MAX) begin
                    m_rel = 1;
                    m_to  = 1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        phi.id_rs = 0; phi.id_rt = 0; phi.id_use_rs = 0; phi.id_use_rt = 0;
        phi.ex_Rw = 0; phi.ex_RegWr = 0; phi.ex_MemtoReg = 0;
        phi.mem_Rw = 0; phi.mem_RegWr = 0; phi.wr_Rw = 0; phi.wr_RegWr = 0;
        phi.ex_rs = 0; phi.ex_rt = 0; phi.ex_branch_taken = 0; phi.id_jump = 0;
        phi.dmem_req = 0; phi.dmem_ready = 0;
    endtask

    task automatic set_loaduse();
        phi.ex_MemtoReg = 2'b01; phi.ex_RegWr = 1; phi.ex_Rw = 5'd9;
        phi.id_use_rt = 1; phi.id_rt = 5'd9;
    endtask

    task automatic rand_inputs(input bit stubborn);
        phi.id_rs = 5'($urandom_range(0, 3));
        phi.id_rt = 5'($urandom_range(0, 3));
        phi.id_use_rs = 1'($urandom_range(0, 1));
        phi.id_use_rt = 1'($urandom_range(0, 1));
        phi.ex_Rw = 5'($urandom_range(0, 3));
        phi.ex_RegWr = 1'($urandom_range(0, 1));
        phi.ex_MemtoReg = 2'($urandom_range(0, 3));
        phi.mem_Rw = 5'($urandom_range(0, 3));
        phi.mem_RegWr = 1'($urandom_range(0, 1));
        phi.wr_Rw = 5'($urandom_range(0, 3));
        phi.wr_RegWr = 1'($urandom_range(0, 1));
        phi.ex_rs = 5'($urandom_range(0, 3));
        phi.ex_rt = 5'($urandom_range(0, 3));
        phi.ex_branch_taken = ($urandom_range(0, 5) == 0);
        phi.id_jump = ($urandom_range(0, 5) == 0);
        if (stubborn) begin
            phi.dmem_req = 1;
            phi.dmem_ready = ($urandom_range(0, 9) == 0);
        end else begin
            phi.dmem_req = ($urandom_range(0, 3) == 0);
            phi.dmem_ready = ($urandom_range(0, 4) < 3);
        end
    endtask

    initial begin
        idle_inputs();
        // Reset: outputs forced free-flowing even with a forwarding match present.
        rst = 0;
        phi.mem_RegWr = 1; phi.mem_Rw = 5'd8; phi.ex_rs = 5'd8;
        @(negedge clk);
        tick();
        #1;
        check("rst_fwd_a", phi.fwd_a, 0);
        check("rst_pc_en", phi.pc_en, 1);
        check("rst_stall_cnt", phi.stall_cnt, 0);
        check("rst_timeout", phi.dmem_timeout, 0);
        tick();
        rst = 1;

        // Forwarding priority and the $0 exclusion.
        phi.wr_RegWr = 1; phi.wr_Rw = 5'd8;
        #1 check("fwd_mem_prio", phi.fwd_a, 2'b01);
        tick();
        phi.mem_Rw = 5'd3;
        #1 check("fwd_wr", phi.fwd_a, 2'b10);
        tick();
        phi.mem_Rw = 0; phi.wr_Rw = 0;
        #1 check("fwd_zero", phi.fwd_a, 2'b00);
        tick();
        idle_inputs();

        // Load-use: one stall cycle.
        set_loaduse();
        #1 check("lu_ctrl", {phi.pc_en, phi.if_id_en, phi.id_ex_flush}, 3'b001);
        tick();
        idle_inputs();
        #1 check("lu_stall_cnt", phi.stall_cnt, 1);
        check("lu_release_pc_en", phi.pc_en, 1);
        tick();

        // Branch overrides simultaneous load-use.
        set_loaduse();
        phi.ex_branch_taken = 1;
        #1 check("br_ctrl", {phi.pc_en, phi.if_id_flush, phi.id_ex_flush}, 3'b111);
        tick();
        idle_inputs();
        #1 check("br_flush_cnt", phi.flush_cnt, 1);
        check("br_stall_cnt", phi.stall_cnt, 1);

        // Three-cycle memory wait.
        phi.dmem_req = 1; phi.dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check("mw_hold", {phi.pc_en, phi.if_id_en, phi.id_ex_en, phi.ex_mem_en,
                                  phi.mem_wr_en, phi.mem_wr_flush}, 6'b000011);
            tick();
        end
        phi.dmem_ready = 1;
        #1 check("mw_done_pc_en", phi.pc_en, 1);
        tick();
        #1 check("mw_stall_cnt", phi.stall_cnt, 4);

        // Timeout: WAIT_MAX stalls, one release cycle, then stalling resumes.
        phi.dmem_ready = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            #1 check("to_hold_pc_en", phi.pc_en, 0);
            tick();
        end
        #1 check("to_rel_ctrl", {phi.pc_en, phi.if_id_en, phi.id_ex_en, phi.ex_mem_en,
                                  phi.mem_wr_flush}, 5'b11110);
        check("to_flag", phi.dmem_timeout, 1);
        check("to_stall_cnt", phi.stall_cnt, 8);
        tick();
        #1 check("to_resume_pc_en", phi.pc_en, 0);
        tick();
        tick();

        // Reset in the middle of a wait.
        rst = 0;
        #1 check("rstw_pc_en", phi.pc_en, 1);
        tick();
        rst = 1;
        #1 check("rstw_stall_cnt", phi.stall_cnt, 0);
        check("rstw_timeout", phi.dmem_timeout, 0);
        check("rstw_restall", phi.pc_en, 0);
        tick();
        idle_inputs();
        tick();

        // Counter saturation.
        set_loaduse();
        for (int i = 0; i < CNT_MAX + 4; i++) tick();
        #1 check("sat_stall_cnt", phi.stall_cnt, CNT_MAX);
        idle_inputs();
        tick();

        // Randomized traffic, in stretches of calm or stubborn memory.
        for (int blk = 0; blk < 200; blk++) begin
            bit stubborn;
            stubborn = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 16; i++) begin
                rand_inputs(stubborn);
                rst = ($urandom_range(0, 99) != 0);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
